// File: rtl/mem_arbiter.sv
// Memory port arbiter for video fetch, disk-copy DMA and CPU: fixed priority VID > DMA > CPU,
// with a DMA burst limit that lets a waiting CPU in. Define MEM_ARB_TIMEOUT_EN for the WAIT timeout.
module mem_arbiter #(
   parameter int BURST_MAX = 8
`ifdef MEM_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 64
`endif
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [1:0]  cpu_wtbt,
   input  logic [24:0] cpu_addr,
   input  logic [15:0] cpu_din,
   output logic [15:0] cpu_dout,
   output logic        cpu_ack,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [24:0] dma_addr,
   input  logic [15:0] dma_din,
   output logic [15:0] dma_dout,
   output logic        dma_ack,
   input  logic        vid_req,
   input  logic [24:0] vid_addr,
   output logic [15:0] vid_dout,
   output logic        vid_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic [1:0]  mem_be,
   output logic [24:0] mem_addr,
   output logic [15:0] mem_din,
   input  logic [15:0] mem_dout,
   input  logic        mem_ack,
   output logic [1:0]  busy_owner
`ifdef MEM_ARB_TIMEOUT_EN
   ,
   output logic        timeout_flag
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_CPU  = 2'd1;
   localparam logic [1:0] OWN_DMA  = 2'd2;
   localparam logic [1:0] OWN_VID  = 2'd3;
   localparam logic [7:0] BURST_MAX_C = 8'(BURST_MAX);

   state_t      state_r, state_s;
   logic [1:0]  owner_r, owner_s, sel_s;
   logic        we_r, we_s;
   logic [1:0]  be_r, be_s;
   logic [24:0] addr_r, addr_s;
   logic [15:0] din_r, din_s;
   logic [7:0]  burst_cnt_r, burst_cnt_s;
   logic        mem_req_r, mem_req_s;
   logic [1:0]  busy_owner_r, busy_owner_s;
   logic [15:0] cpu_dout_r, cpu_dout_s, dma_dout_r, dma_dout_s, vid_dout_r, vid_dout_s;
   logic        cpu_ack_r, cpu_ack_s, dma_ack_r, dma_ack_s, vid_ack_r, vid_ack_s;
   logic        done_s;
   logic [15:0] rdata_s;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   logic [TO_W-1:0] to_cnt_r, to_cnt_s;
   logic            to_flag_r, to_flag_s;
`endif

   // Next-state, transaction latch, burst counter and read-data capture.
   always_comb begin
      state_s      = state_r;
      owner_s      = owner_r;
      we_s         = we_r;
      be_s         = be_r;
      addr_s       = addr_r;
      din_s        = din_r;
      burst_cnt_s  = burst_cnt_r;
      mem_req_s    = mem_req_r;
      busy_owner_s = busy_owner_r;
      cpu_dout_s   = cpu_dout_r;
      dma_dout_s   = dma_dout_r;
      vid_dout_s   = vid_dout_r;
      cpu_ack_s    = 1'b0;
      dma_ack_s    = 1'b0;
      vid_ack_s    = 1'b0;
      sel_s        = OWN_NONE;
      done_s       = 1'b0;
      rdata_s      = mem_dout;
`ifdef MEM_ARB_TIMEOUT_EN
      to_cnt_s     = TO_W'(0);
      to_flag_s    = to_flag_r;
`endif
      case (state_r)
         ST_IDLE: begin
            // A full burst lets a waiting CPU ahead of DMA, never ahead of video.
            if (vid_req)                                        sel_s = OWN_VID;
            else if (cpu_req && (burst_cnt_r == BURST_MAX_C))   sel_s = OWN_CPU;
            else if (dma_req)                                   sel_s = OWN_DMA;
            else if (cpu_req)                                   sel_s = OWN_CPU;
            else                                                sel_s = OWN_NONE;

            case (sel_s)
               OWN_VID: begin
                  we_s = 1'b0;   be_s = 2'b11;  addr_s = vid_addr;  din_s = 16'h0000;
               end
               OWN_DMA: begin
                  we_s = dma_we; be_s = 2'b11;  addr_s = dma_addr;  din_s = dma_din;
               end
               OWN_CPU: begin
                  we_s = cpu_we; be_s = cpu_we ? cpu_wtbt : 2'b11;
                  addr_s = cpu_addr; din_s = cpu_din;
               end
               default: begin
                  we_s = we_r;
               end
            endcase

            if (sel_s == OWN_CPU)
               burst_cnt_s = 8'd0;
            else if (sel_s == OWN_DMA)
               burst_cnt_s = (burst_cnt_r == BURST_MAX_C) ? burst_cnt_r : burst_cnt_r + 8'd1;
            else if (!dma_req)
               burst_cnt_s = 8'd0;
            else
               burst_cnt_s = burst_cnt_r;

            owner_s      = sel_s;
            busy_owner_s = sel_s;
            mem_req_s    = (sel_s != OWN_NONE);
            state_s      = (sel_s != OWN_NONE) ? ST_GRANT : ST_IDLE;
         end
         ST_GRANT: begin
            state_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_ack) begin
               done_s = 1'b1;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (to_cnt_r == TO_LAST) begin
               done_s    = 1'b1;
               rdata_s   = 16'hFFFF;
               to_flag_s = 1'b1;
            end else begin
               to_cnt_s  = to_cnt_r + TO_W'(1);
            end
`else
            else begin
               done_s = 1'b0;
            end
`endif
            if (done_s) begin
               mem_req_s = 1'b0;
               state_s   = ST_DONE;
               cpu_ack_s = (owner_r == OWN_CPU);
               dma_ack_s = (owner_r == OWN_DMA);
               vid_ack_s = (owner_r == OWN_VID);
               if (!we_r) begin
                  case (owner_r)
                     OWN_CPU: cpu_dout_s = rdata_s;
                     OWN_DMA: dma_dout_s = rdata_s;
                     OWN_VID: vid_dout_s = rdata_s;
                     default: cpu_dout_s = cpu_dout_r;
                  endcase
               end else begin
                  cpu_dout_s = cpu_dout_r;
               end
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_DONE: begin
            state_s      = ST_IDLE;
            busy_owner_s = OWN_NONE;
         end
         default: begin
            state_s      = ST_IDLE;
            mem_req_s    = 1'b0;
            busy_owner_s = OWN_NONE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any transaction in flight.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         owner_r      <= OWN_NONE;
         we_r         <= 1'b0;
         be_r         <= 2'b00;
         addr_r       <= 25'd0;
         din_r        <= 16'h0000;
         burst_cnt_r  <= 8'd0;
         mem_req_r    <= 1'b0;
         busy_owner_r <= OWN_NONE;
         cpu_dout_r   <= 16'h0000;
         dma_dout_r   <= 16'h0000;
         vid_dout_r   <= 16'h0000;
         cpu_ack_r    <= 1'b0;
         dma_ack_r    <= 1'b0;
         vid_ack_r    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         to_cnt_r     <= TO_W'(0);
         to_flag_r    <= 1'b0;
`endif
      end else begin
         state_r      <= state_s;
         owner_r      <= owner_s;
         we_r         <= we_s;
         be_r         <= be_s;
         addr_r       <= addr_s;
         din_r        <= din_s;
         burst_cnt_r  <= burst_cnt_s;
         mem_req_r    <= mem_req_s;
         busy_owner_r <= busy_owner_s;
         cpu_dout_r   <= cpu_dout_s;
         dma_dout_r   <= dma_dout_s;
         vid_dout_r   <= vid_dout_s;
         cpu_ack_r    <= cpu_ack_s;
         dma_ack_r    <= dma_ack_s;
         vid_ack_r    <= vid_ack_s;
`ifdef MEM_ARB_TIMEOUT_EN
         to_cnt_r     <= to_cnt_s;
         to_flag_r    <= to_flag_s;
`endif
      end
   end

   assign mem_req    = mem_req_r;
   assign mem_we     = we_r;
   assign mem_be     = be_r;
   assign mem_addr   = addr_r;
   assign mem_din    = din_r;
   assign busy_owner = busy_owner_r;
   assign cpu_dout   = cpu_dout_r;
   assign dma_dout   = dma_dout_r;
   assign vid_dout   = vid_dout_r;
   assign cpu_ack    = cpu_ack_r;
   assign dma_ack    = dma_ack_r;
   assign vid_ack    = vid_ack_r;
`ifdef MEM_ARB_TIMEOUT_EN
   assign timeout_flag = to_flag_r;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-timeline reference model (grant edge, memory latency, ack edge).
module tb_mem_arbiter;
   localparam int BURST_MAX = 8;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam int TIMEOUT_CYC = 64;
`endif

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [1:0]  cpu_wtbt = 2'b00;
   logic [24:0] cpu_addr = 25'd0;
   logic [15:0] cpu_din = 16'h0000;
   logic        dma_req = 1'b0, dma_we = 1'b0;
   logic [24:0] dma_addr = 25'd0;
   logic [15:0] dma_din = 16'h0000;
   logic        vid_req = 1'b0;
   logic [24:0] vid_addr = 25'd0;
   logic [15:0] mem_dout = 16'h0000;
   logic        mem_ack = 1'b0;
   logic [15:0] cpu_dout, dma_dout, vid_dout;
   logic        cpu_ack, dma_ack, vid_ack;
   logic        mem_req, mem_we;
   logic [1:0]  mem_be, busy_owner;
   logic [24:0] mem_addr;
   logic [15:0] mem_din;
`ifdef MEM_ARB_TIMEOUT_EN
   logic        timeout_flag;
`endif

   always #5 clk_sys = ~clk_sys;

   mem_arbiter #(
      .BURST_MAX(BURST_MAX)
`ifdef MEM_ARB_TIMEOUT_EN
      , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
   ) dut (
      .clk_sys(clk_sys), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_wtbt(cpu_wtbt), .cpu_addr(cpu_addr),
      .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
      .dma_dout(dma_dout), .dma_ack(dma_ack),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack),
      .busy_owner(busy_owner)
`ifdef MEM_ARB_TIMEOUT_EN
      , .timeout_flag(timeout_flag)
`endif
   );

   int checks = 0;
   int failures = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference model: a transaction is a grant edge plus an ack edge; everything else follows.
   int          cyc = 0;
   bit          in_tx = 1'b0, in_done = 1'b0, ack_now = 1'b0;
   int          grant_edge = 0, ack_edge = 0;
   logic [1:0]  m_owner = 2'd0, m_be = 2'd0;
   logic        m_we = 1'b0;
   logic [24:0] m_addr = 25'd0;
   logic [15:0] m_din = 16'h0, m_rdata = 16'h0;
   int          m_burst = 0;
   logic [15:0] e_cpu_dout = 16'h0, e_dma_dout = 16'h0, e_vid_dout = 16'h0;
   bit          e_to_flag = 1'b0;
   int          fixed_lat = 0;
   bit          fixed_data_en = 1'b0, spur_en = 1'b0, no_ack = 1'b0;
   logic [15:0] fixed_data = 16'h0;
   logic [1:0]  dut_log[$];
   bit          prev_req = 1'b0;
   logic [1:0]  last_be = 2'd0;
   logic        last_we = 1'b0;

   task automatic step();
      logic [1:0] win;
      logic [2:0] exp_acks;
      int         lat;
      @(posedge clk_sys);
      #1;
      cyc++;
      ack_now = 1'b0;
      if (reset) begin
         in_tx = 1'b0; in_done = 1'b0; m_burst = 0; e_to_flag = 1'b0; prev_req = 1'b0;
         e_cpu_dout = 16'h0; e_dma_dout = 16'h0; e_vid_dout = 16'h0;
         check_val("rst_ctl", {mem_req, mem_we, mem_be, cpu_ack, dma_ack, vid_ack, busy_owner}, 32'd0);
         check_val("rst_data", {mem_addr, mem_din}, 32'd0);
         check_val("rst_dout", {cpu_dout, dma_dout}, 32'd0);
         check_val("rst_vdout", vid_dout, 32'd0);
      end else begin
         if (in_tx && cyc == ack_edge) begin
            in_tx = 1'b0; in_done = 1'b1; ack_now = 1'b1;
            if (no_ack) e_to_flag = 1'b1;
            if (!m_we) begin
               if (m_owner == 2'd1) e_cpu_dout = m_rdata;
               else if (m_owner == 2'd2) e_dma_dout = m_rdata;
               else e_vid_dout = m_rdata;
            end
         end else if (in_done) begin
            in_done = 1'b0;
         end else if (!in_tx) begin
            if (vid_req) win = 2'd3;
            else if (cpu_req && m_burst == BURST_MAX) win = 2'd1;
            else if (dma_req) win = 2'd2;
            else if (cpu_req) win = 2'd1;
            else win = 2'd0;
            if (win == 2'd1) m_burst = 0;
            else if (win == 2'd2) m_burst = (m_burst < BURST_MAX) ? m_burst + 1 : BURST_MAX;
            else if (!dma_req) m_burst = 0;
            if (win != 2'd0) begin
               m_owner = win;
               if (win == 2'd3) begin
                  m_we = 1'b0; m_be = 2'b11; m_addr = vid_addr; m_din = 16'h0;
               end else if (win == 2'd2) begin
                  m_we = dma_we; m_be = 2'b11; m_addr = dma_addr; m_din = dma_din;
               end else begin
                  m_we = cpu_we; m_be = cpu_we ? cpu_wtbt : 2'b11; m_addr = cpu_addr; m_din = cpu_din;
               end
               lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
`ifdef MEM_ARB_TIMEOUT_EN
               if (no_ack) lat = TIMEOUT_CYC;
`endif
               m_rdata = no_ack ? 16'hFFFF : (fixed_data_en ? fixed_data : 16'($urandom));
               in_tx = 1'b1; grant_edge = cyc; ack_edge = cyc + lat + 1;
            end
         end
         exp_acks = !ack_now ? 3'b000 : (m_owner == 2'd1) ? 3'b100 : (m_owner == 2'd2) ? 3'b010 : 3'b001;
         check_val("mem_req", mem_req, in_tx);
         check_val("busy_owner", busy_owner, (in_tx || in_done) ? m_owner : 2'd0);
         check_val("acks", {cpu_ack, dma_ack, vid_ack}, exp_acks);
         if (in_tx) begin
            check_val("mem_addr", mem_addr, m_addr);
            check_val("mem_we_be", {mem_we, mem_be}, {m_we, m_be});
            if (m_we) check_val("mem_din", mem_din, m_din);
         end
         check_val("cpu_dout", cpu_dout, e_cpu_dout);
         check_val("dma_dout", dma_dout, e_dma_dout);
         check_val("vid_dout", vid_dout, e_vid_dout);
`ifdef MEM_ARB_TIMEOUT_EN
         check_val("timeout_flag", timeout_flag, e_to_flag);
`endif
         if (mem_req === 1'b1 && !prev_req) begin
            dut_log.push_back(busy_owner);
            last_be = mem_be;
            last_we = mem_we;
         end
         prev_req = (mem_req === 1'b1);
      end
      // Memory side: real ack when the model's latency elapses, stray acks where they must be ignored.
      mem_ack = 1'b0;
      if (!reset && in_tx && !no_ack && cyc + 1 == ack_edge) begin
         mem_ack = 1'b1; mem_dout = m_rdata;
      end else if (!reset && spur_en && (!in_tx || cyc == grant_edge) && $urandom_range(0, 7) == 0) begin
         mem_ack = 1'b1; mem_dout = 16'($urandom);
      end
   endtask

   task automatic run_until_ack(input logic [1:0] who, input string tag);
      int n = 0;
      do begin
         step();
         n++;
      end while (!(ack_now && m_owner == who) && n < 200);
      check_val(tag, {cpu_ack, dma_ack, vid_ack}, (who == 2'd1) ? 3'b100 : (who == 2'd2) ? 3'b010 : 3'b001);
   endtask

   task automatic drive_random();
      if (ack_now && m_owner == 2'd1) cpu_req = 1'b0;
      else if (!cpu_req && $urandom_range(0, 3) == 0) begin
         cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1)); cpu_wtbt = 2'($urandom);
         cpu_addr = 25'($urandom); cpu_din = 16'($urandom);
      end
      if (ack_now && m_owner == 2'd2) begin
         dma_req = ($urandom_range(0, 7) != 0);
         dma_we = 1'($urandom_range(0, 1)); dma_addr = 25'($urandom); dma_din = 16'($urandom);
      end else if (!dma_req && $urandom_range(0, 5) == 0) begin
         dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1));
         dma_addr = 25'($urandom); dma_din = 16'($urandom);
      end
      if (ack_now && m_owner == 2'd3) vid_req = 1'b0;
      else if (vid_req && in_tx && m_owner == 2'd3 && cyc == grant_edge && $urandom_range(0, 1) == 0)
         vid_req = 1'b0;
      else if (!vid_req && !((in_tx || in_done) && m_owner == 2'd3) && $urandom_range(0, 11) == 0) begin
         vid_req = 1'b1; vid_addr = 25'($urandom);
      end
   endtask

   initial begin
      logic [1:0] exp_seq [11];
      int start, n;
      exp_seq = '{2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2};
      step();
      step();
      reset = 1'b0;
      repeat (3) step();

      // Single CPU read, memory answers 16'h1234 two cycles into WAIT.
      fixed_lat = 2; fixed_data_en = 1'b1; fixed_data = 16'h1234;
      cpu_addr = 25'h1000; cpu_we = 1'b0; cpu_wtbt = 2'b01; cpu_req = 1'b1;
      run_until_ack(2'd1, "a_cpu_ack");
      cpu_req = 1'b0;
      check_val("a_cpu_dout", cpu_dout, 16'h1234);
      check_val("a_be_we", {last_we, last_be}, 3'b011);
      step();
      check_val("a_ack_pulse", cpu_ack, 1'b0);
      fixed_lat = 0; fixed_data_en = 1'b0;

      // CPU byte write: only the upper lane, read data left alone.
      cpu_we = 1'b1; cpu_wtbt = 2'b10; cpu_din = 16'hAB00; cpu_addr = 25'h2000; cpu_req = 1'b1;
      run_until_ack(2'd1, "b_cpu_ack");
      cpu_req = 1'b0;
      check_val("b_be_we", {last_we, last_be}, 3'b110);
      check_val("b_cpu_dout", cpu_dout, 16'h1234);
      repeat (2) step();

      // All three at once with DMA held: VID, eight DMA, CPU, DMA again.
      start = dut_log.size();
      vid_req = 1'b1; vid_addr = 25'h0300;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 25'h0400;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0500;
      n = 0;
      while (dut_log.size() < start + 11 && n < 400) begin
         step();
         n++;
         if (ack_now && m_owner == 2'd3) vid_req = 1'b0;
         if (ack_now && m_owner == 2'd1) cpu_req = 1'b0;
         if (ack_now && m_owner == 2'd2) dma_addr = dma_addr + 25'd1;
      end
      dma_req = 1'b0;
      check_val("c_grant_count", dut_log.size() - start, 11);
      for (int i = 0; i < 11 && start + i < dut_log.size(); i++)
         check_val($sformatf("c_grant%0d", i), dut_log[start + i], exp_seq[i]);
      n = 0;
      while ((in_tx || in_done) && n < 50) begin
         step();
         n++;
      end
      step();

      // Reset while waiting on memory: everything drops, no ack, then normal service.
      fixed_lat = 6; cpu_we = 1'b0; cpu_addr = 25'h0777; cpu_req = 1'b1;
      n = 0;
      while (!(in_tx && cyc >= grant_edge + 2) && n < 50) begin
         step();
         n++;
      end
      check_val("d_in_wait", mem_req, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check_val("d_rst_ctl", {mem_req, busy_owner, cpu_ack}, 4'd0);
      check_val("d_rst_dout", cpu_dout, 16'h0000);
      step();
      reset = 1'b0;
      fixed_lat = 0;
      run_until_ack(2'd1, "d_after_rst");
      cpu_req = 1'b0;
      repeat (2) step();

`ifdef MEM_ARB_TIMEOUT_EN
      // Memory never answers a DMA read: timeout returns all ones and sets the sticky flag.
      no_ack = 1'b1; dma_we = 1'b0; dma_addr = 25'h0999; dma_req = 1'b1;
      run_until_ack(2'd2, "e_to_ack");
      dma_req = 1'b0;
      check_val("e_to_dout", dma_dout, 16'hFFFF);
      no_ack = 1'b0;
      repeat (4) step();
      check_val("e_to_sticky", timeout_flag, 1'b1);
`endif

      // Randomized traffic with stray memory acks.
      spur_en = 1'b1;
      repeat (3000) begin
         step();
         drive_random();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between three requesters:
  - video refresh fetch
  - disk-image copy DMA
  - CPU bus cycle
- Sits between the CPU/disk/video logic and the memory block; one transaction is outstanding at a time.
- Fixed priority VID > DMA > CPU, with a DMA burst limit so the CPU is never starved while a disk copy runs.

Parameters:
- BURST_MAX, 8: max consecutive DMA grants before one pending CPU request must be served (1..255).
- TIMEOUT_CYC, 64: cycles to wait for mem_ack before abort (used only with the optional feature).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, level; held until cpu_ack
- cpu_we  in  1  CPU write
- cpu_wtbt  in  2  CPU byte enables
- cpu_addr  in  25  CPU physical word address
- cpu_din  in  16  CPU write data
- cpu_dout  out  16  CPU read data
- cpu_ack  out  1  one-cycle completion pulse
- dma_req  in  1  disk copy request, level
- dma_we  in  1  DMA write
- dma_addr  in  25  DMA address
- dma_din  in  16  DMA write data
- dma_dout  out  16  DMA read data
- dma_ack  out  1  one-cycle completion pulse
- vid_req  in  1  video fetch request (read only)
- vid_addr  in  25  video address
- vid_dout  out  16  video read data
- vid_ack  out  1  one-cycle completion pulse
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_be  out  2  memory byte enables
- mem_addr  out  25  memory address
- mem_din  out  16  memory write data
- mem_dout  in  16  memory read data
- mem_ack  in  1  memory completion pulse
- busy_owner  out  2  current owner: 0 none, 1 CPU, 2 DMA, 3 VID

Behaviour:
- Reset: all outputs 0, FSM IDLE, burst counter 0. Reset asserted mid-transaction abandons it with no ack.
- FSM states are IDLE, GRANT, WAIT, DONE.
- IDLE:
  - Evaluate requests each cycle.
  - Owner = VID if vid_req.
  - Else CPU if cpu_req and burst_cnt == BURST_MAX.
  - Else DMA if dma_req.
  - Else CPU if cpu_req.
  - Latch owner and that requester's addr/we/be/data into registers; go to GRANT.
- Byte enables:
  - DMA and VID always use be = 2'b11.
  - VID we is forced to 0.
  - CPU uses cpu_wtbt, or 2'b11 on reads.
- GRANT: assert mem_req with the latched signals; go to WAIT.
- WAIT:
  - Hold mem_req and all mem_* stable until mem_ack.
  - On mem_ack: drop mem_req, capture mem_dout into the owner's dout register, go to DONE.
- DONE:
  - Pulse the owner's ack for exactly one cycle; return to IDLE.
  - Request-to-ack latency is 3 cycles plus memory latency; minimum gap between grants is 1 IDLE cycle.
- Read-data hold: each requester's dout holds its last read value until that requester's next read completes. Writes do not update dout.
- Burst counter:
  - Increments on each DMA grant, saturating at BURST_MAX.
  - Clears on any CPU grant, and whenever dma_req is low in IDLE.
  - VID grants leave it unchanged.
- Starvation guard: when burst_cnt == BURST_MAX and cpu_req is high, the CPU wins over DMA but not over VID.
- Simultaneous events:
  - A request sampled in IDLE in the same cycle as another is resolved purely by the priority above.
  - A request dropping after its grant does not cancel the transaction; its ack still pulses.
- mem_ack outside WAIT is ignored.
- busy_owner is valid from GRANT through DONE and is 0 in IDLE.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT. If TIMEOUT_CYC cycles pass without mem_ack, the FSM drops mem_req and goes to DONE.
  - Read data returned is 16'hFFFF; the owner's ack pulses normally.
  - Sticky output timeout_flag (1 bit) sets and clears only on reset.
- When undefined: WAIT lasts indefinitely, timeout_flag is absent, and there is no counter logic.

Test Plan:
- Single CPU read at 25'h1000, memory returns 16'h1234 after 2 cycles -> one mem_req with we=0, be=2'b11; cpu_ack is a 1-cycle pulse; cpu_dout=16'h1234; busy_owner=1 during the transaction.
- vid_req, dma_req and cpu_req asserted in the same cycle -> grant order is VID, DMA, then DMA repeatedly until the burst limit, then CPU. Each ack pulses exactly once per transaction.
- dma_req held high with BURST_MAX=8 and cpu_req raised -> exactly 8 DMA grants, then one CPU grant, then DMA resumes with burst_cnt=1.
- CPU byte write, cpu_wtbt=2'b10, data 16'hAB00 -> mem_be=2'b10 and mem_we=1; cpu_dout unchanged from its previous read value.
- reset asserted while in WAIT with mem_req=1 -> outputs 0 immediately; no ack pulse; after release, the next request is served normally.
- With MEM_ARB_TIMEOUT_EN and mem_ack never asserted on a DMA read -> dma_ack pulses after TIMEOUT_CYC cycles with dma_dout=16'hFFFF; timeout_flag=1 and stays set.
